// File: rtl/cpu.sv
// Single-cycle 16-bit accumulator core (BIP-I style) with external Harvard memories.
// Decode is purely combinational; PC and ACC are the only state.
module cpu #(
  parameter int PC_W   = 11,
  parameter int DATA_W = 16,
  parameter int OPC_W  = 5
) (
  input  logic              clk,
  input  logic              reset,
  output logic [PC_W-1:0]   addr_program,
  input  logic [DATA_W-1:0] data,
  output logic              rd,
  output logic              wr,
  output logic [PC_W-1:0]   addr_data,
  input  logic [DATA_W-1:0] in_data,
  output logic [DATA_W-1:0] out_data
);

  typedef enum logic [OPC_W-1:0] {
    OP_HLT  = 5'b00000,
    OP_STO  = 5'b00001,
    OP_LD   = 5'b00010,
    OP_LDI  = 5'b00011,
    OP_ADD  = 5'b00100,
    OP_ADDI = 5'b00101,
    OP_SUB  = 5'b00110,
    OP_SUBI = 5'b00111
  } opcode_e;

  logic [PC_W-1:0]   pc_q, pc_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [OPC_W-1:0]  opc;
  logic [PC_W-1:0]   operand;
  logic [DATA_W-1:0] imm;

  assign opc     = data[DATA_W-1 -: OPC_W];
  assign operand = data[PC_W-1:0];
  assign imm     = {{(DATA_W-PC_W){operand[PC_W-1]}}, operand};

  assign addr_program = pc_q;
  assign addr_data    = operand;
  assign out_data     = acc_q;

  always_comb begin
    rd    = 1'b0;
    wr    = 1'b0;
    acc_d = acc_q;
    pc_d  = pc_q + {{(PC_W-1){1'b0}}, 1'b1};
    // Opcodes 01000..11111 fall through as NOPs.
    case (opc)
      OP_HLT:  pc_d  = pc_q;
      OP_STO:  wr    = 1'b1;
      OP_LD:   begin rd = 1'b1; acc_d = in_data; end
      OP_LDI:  acc_d = imm;
      OP_ADD:  begin rd = 1'b1; acc_d = acc_q + in_data; end
      OP_ADDI: acc_d = acc_q + imm;
      OP_SUB:  begin rd = 1'b1; acc_d = acc_q - in_data; end
      OP_SUBI: acc_d = acc_q - imm;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q  <= '0;
      acc_q <= '0;
    end else begin
      pc_q  <= pc_d;
      acc_q <= acc_d;
    end
  end

endmodule

// File: tb/tb_cpu.sv
// Scoreboard bench for cpu: each stimulus cycle queues the expected outputs,
// a negedge monitor pops and compares them.
module tb_cpu;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [10:0] addr_program;
  logic [15:0] data = '0;
  logic        rd, wr;
  logic [10:0] addr_data;
  logic [15:0] in_data = '0;
  logic [15:0] out_data;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string       name;
    logic [10:0] pc;
    logic        rd;
    logic        wr;
    logic [10:0] ad;
    logic [15:0] out;
  } exp_t;

  exp_t q[$];

  cpu dut (
    .clk(clk), .reset(reset), .addr_program(addr_program), .data(data),
    .rd(rd), .wr(wr), .addr_data(addr_data), .in_data(in_data), .out_data(out_data)
  );

  always #5 clk = ~clk;

  // Monitor: outputs are settled by the falling edge of each cycle.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      total++;
      if (addr_program !== e.pc || rd !== e.rd || wr !== e.wr ||
          addr_data !== e.ad || out_data !== e.out) begin
        bad++;
        $display("FAIL %s: got pc=%0d rd=%b wr=%b ad=%h out=%h, want pc=%0d rd=%b wr=%b ad=%h out=%h",
                 e.name, addr_program, rd, wr, addr_data, out_data,
                 e.pc, e.rd, e.wr, e.ad, e.out);
      end
    end
  end

  // Drive one cycle's inputs just after the rising edge and queue its expectation.
  task automatic cyc(input string name, input logic rst, input logic [15:0] d,
                     input logic [15:0] din, input logic [10:0] pc, input logic erd,
                     input logic ewr, input logic [10:0] ad, input logic [15:0] out);
    exp_t e;
    @(posedge clk);
    #1;
    reset   = rst;
    data    = d;
    in_data = din;
    e.name = name; e.pc = pc; e.rd = erd; e.wr = ewr; e.ad = ad; e.out = out;
    q.push_back(e);
  endtask

  initial begin
    // Reset held with HLT on the bus, then an LD word to show rd follows decode.
    for (int i = 0; i < 5; i++)
      cyc("reset_hold", 1'b1, 16'h0000, 16'h0, 11'd0, 1'b0, 1'b0, 11'h000, 16'h0000);
    cyc("reset_decode", 1'b1, 16'h1001, 16'h7, 11'd0, 1'b1, 1'b0, 11'h001, 16'h0000);

    cyc("ld1",   1'b0, 16'h1001, 16'h7, 11'd0, 1'b1, 1'b0, 11'h001, 16'h0000);
    cyc("addi5", 1'b0, 16'h2805, 16'h0, 11'd1, 1'b0, 1'b0, 11'h005, 16'h0007);
    cyc("sto8",  1'b0, 16'h0808, 16'h0, 11'd2, 1'b0, 1'b1, 11'h008, 16'h000C);
    for (int i = 0; i < 3; i++)
      cyc("halt", 1'b0, 16'h0000, 16'h0, 11'd3, 1'b0, 1'b0, 11'h000, 16'h000C);
    // Reset raised 1ns after an edge; must clear before the next edge.
    cyc("async_rst", 1'b1, 16'h0000, 16'h0, 11'd0, 1'b0, 1'b0, 11'h000, 16'h0000);

    cyc("ldi_m1",  1'b0, 16'h1FFF, 16'h0, 11'd0, 1'b0, 1'b0, 11'h7FF, 16'h0000);
    cyc("subi1",   1'b0, 16'h3801, 16'h0, 11'd1, 1'b0, 1'b0, 11'h001, 16'hFFFF);
    cyc("add2",    1'b0, 16'h2003, 16'h2, 11'd2, 1'b1, 1'b0, 11'h003, 16'hFFFE);
    cyc("sub5",    1'b0, 16'h3004, 16'h5, 11'd3, 1'b1, 1'b0, 11'h004, 16'h0000);
    cyc("nop_lo",  1'b0, 16'h4000, 16'h9, 11'd4, 1'b0, 1'b0, 11'h000, 16'hFFFB);
    cyc("nop_hi",  1'b0, 16'hF8AA, 16'h9, 11'd5, 1'b0, 1'b0, 11'h0AA, 16'hFFFB);
    for (int p = 6; p <= 2047; p++)
      cyc("nop_run", 1'b0, 16'h4000, 16'h0, 11'(p), 1'b0, 1'b0, 11'h000, 16'hFFFB);
    cyc("pc_wrap", 1'b0, 16'h1805, 16'h0, 11'd0, 1'b0, 1'b0, 11'h005, 16'hFFFB);
    cyc("sto9",    1'b0, 16'h0809, 16'h0, 11'd1, 1'b0, 1'b1, 11'h009, 16'h0005);
    cyc("addi_m2", 1'b0, 16'h2FFE, 16'h0, 11'd2, 1'b0, 1'b0, 11'h7FE, 16'h0005);
    cyc("halt2",   1'b0, 16'h0000, 16'h0, 11'd3, 1'b0, 1'b0, 11'h000, 16'h0003);
    cyc("halt2",   1'b0, 16'h0000, 16'h0, 11'd3, 1'b0, 1'b0, 11'h000, 16'h0003);

    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    #1;
    if (q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: sim time exceeded, want completion");
    $fatal(1, "timeout");
  end

endmodule
